binary_quiz_engine: RTL and testbench

//  Parametrised successor of the binary guessing-game controller. It runs the menu, play and practice flows,

---
 rtl/binary_quiz_engine_pkg.sv | 63 ++++++
 rtl/binary_quiz_engine_lfsr_rng.sv | 25 ++
 rtl/binary_quiz_engine.sv | 169 ++++++++++++++++
 tb/tb_binary_quiz_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_quiz_engine_pkg.sv
// Shared definitions for the binary quiz engine: state and menu cursor codes,
// button decoding and the LFSR tap table.
package binary_quiz_engine_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_MENU   = 4'd1,
        S_P_LOAD = 4'd2,
        S_P_WAIT = 4'd3,
        S_OVER   = 4'd4,
        S_R_LOAD = 4'd5,
        S_R_WAIT = 4'd6,
        S_SCORES = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        C_PLAY     = 2'd0,
        C_PRACTICE = 2'd1,
        C_SCORES   = 2'd2,
        C_QUIT     = 2'd3
    } cursor_t;

    typedef struct packed {
        logic select;
        logic quit;
        logic left;
        logic right;
    } buttons_t;

    // A press only counts on an enabled tick with exactly one button held.
    function automatic buttons_t decode_buttons(input logic cen, input logic sel,
                                                input logic quit, input logic left,
                                                input logic right);
        buttons_t b;
        b = '0;
        if (cen && $onehot({sel, quit, left, right}))
            b = {sel, quit, left, right};
        return b;
    endfunction

    // Right-shift Galois feedback masks for maximal-length sequences.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hB400;
        endcase
    endfunction

endpackage

// File: rtl/binary_quiz_engine_lfsr_rng.sv
// Free-running WIDTH-bit Galois LFSR; never reaches zero from a non-zero seed.
module lfsr_rng
    import binary_quiz_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEED  = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            value <= SEED_V;
        else if (value[0])
            value <= (value >> 1) ^ TAPS;
        else
            value <= value >> 1;
    end

endmodule

// File: rtl/binary_quiz_engine.sv
// Quiz controller: menu, timed play game with lives and saturating score,
// untimed practice mode, and a retained high score.
module binary_quiz_engine
    import binary_quiz_engine_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned TIME_LIMIT = 200,
    parameter int unsigned SEED       = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               CEN,
    input  logic               Select,
    input  logic               Quit,
    input  logic               selectLeft,
    input  logic               selectRight,
    input  logic [WIDTH-1:0]   userNumber,
    output logic [WIDTH-1:0]   outputNumber,
    output logic [SCORE_W-1:0] playerScore,
    output logic [SCORE_W-1:0] highScore,
    output logic [3:0]         livesLeft,
    output logic [15:0]        timeLeft,
    output logic               isWrong,
    output logic [3:0]         stateOut
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [15:0]        TIME_INIT  = 16'(TIME_LIMIT);

    state_t               state, state_nxt;
    cursor_t              cursor, cursor_nxt;
    logic [WIDTH-1:0]     number, number_nxt, rng;
    logic [SCORE_W-1:0]   score, score_nxt, high, high_nxt;
    logic [3:0]           lives, lives_nxt;
    logic [15:0]          timer, timer_nxt;
    logic                 wrong, wrong_nxt;
    logic                 miss;
    buttons_t             btn;

    lfsr_rng #(.WIDTH(WIDTH), .SEED(SEED)) u_rng (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .value   (rng)
    );

    assign btn = decode_buttons(CEN, Select, Quit, selectLeft, selectRight);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_INIT;
            cursor <= C_PLAY;
            number <= '0;
            score  <= '0;
            high   <= '0;
            lives  <= '0;
            timer  <= '0;
            wrong  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cursor <= cursor_nxt;
            number <= number_nxt;
            score  <= score_nxt;
            high   <= high_nxt;
            lives  <= lives_nxt;
            timer  <= timer_nxt;
            wrong  <= wrong_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        number_nxt = number;
        score_nxt  = score;
        high_nxt   = high;
        lives_nxt  = lives;
        timer_nxt  = timer;
        wrong_nxt  = wrong;
        miss       = 1'b0;
        case (state)
            S_INIT: if (CEN) state_nxt = S_MENU;
            S_MENU: begin
                if (btn.left)
                    cursor_nxt = cursor_t'(cursor - 2'd1);
                else if (btn.right)
                    cursor_nxt = cursor_t'(cursor + 2'd1);
                else if (btn.select) begin
                    case (cursor)
                        C_PLAY: begin
                            state_nxt = S_P_LOAD;
                            score_nxt = '0;
                            lives_nxt = LIVES_INIT;
                        end
                        C_PRACTICE: state_nxt = S_R_LOAD;
                        C_SCORES:   state_nxt = S_SCORES;
                        default:    state_nxt = S_DONE;
                    endcase
                end
            end
            S_P_LOAD: if (CEN) begin
                number_nxt = rng;
                timer_nxt  = TIME_INIT;
                state_nxt  = S_P_WAIT;
            end
            S_P_WAIT: if (CEN) begin
                timer_nxt = timer - 16'd1;
                // Quit wins over a coinciding timeout, so no life is lost.
                if (btn.quit) begin
                    state_nxt  = S_OVER;
                    number_nxt = '0;
                end else if (btn.select) begin
                    if (userNumber == number) begin
                        score_nxt = (score == SCORE_MAX) ? score : score + 1'b1;
                        wrong_nxt = 1'b0;
                        state_nxt = S_P_LOAD;
                    end else begin
                        miss = 1'b1;
                    end
                end else if (timer == 16'd1) begin
                    miss = 1'b1;
                end
                if (miss) begin
                    lives_nxt = lives - 4'd1;
                    wrong_nxt = 1'b1;
                    if (lives > 4'd1) begin
                        state_nxt = S_P_LOAD;
                    end else begin
                        state_nxt  = S_OVER;
                        number_nxt = '0;
                    end
                end
            end
            S_OVER: if (btn.select) state_nxt = S_SCORES;
            S_R_LOAD: if (CEN) begin
                number_nxt = rng;
                state_nxt  = S_R_WAIT;
            end
            S_R_WAIT: begin
                if (btn.select) begin
                    wrong_nxt = (userNumber != number);
                    if (userNumber == number) state_nxt = S_R_LOAD;
                end else if (btn.quit) begin
                    state_nxt  = S_MENU;
                    number_nxt = '0;
                end
            end
            S_SCORES: if (btn.select || btn.quit) begin
                state_nxt  = S_MENU;
                cursor_nxt = C_SCORES;
            end
            S_DONE: if (btn.select) state_nxt = S_INIT;
            default: state_nxt = S_INIT;
        endcase
        if (state_nxt == S_OVER && state != S_OVER && score > high)
            high_nxt = score;
    end

    assign outputNumber = number;
    assign playerScore  = score;
    assign highScore    = high;
    assign livesLeft    = lives;
    assign timeLeft     = timer;
    assign isWrong      = wrong;
    assign stateOut     = state;

endmodule

// File: tb/tb_binary_quiz_engine.sv
// Directed bench for binary_quiz_engine with a per-cycle reference model.
module tb_binary_quiz_engine;
    import binary_quiz_engine_pkg::*;

    localparam int WIDTH = 4;
    localparam int LIVES = 2;
    localparam int TLIM  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen, Select, Quit, selectLeft, selectRight;
    logic [3:0] userNumber;

    logic [3:0]  num_a, num_b;
    logic [7:0]  score_a, high_a;
    logic [1:0]  score_b, high_b;
    logic [3:0]  lives_a, lives_b, state_a, state_b;
    logic [15:0] time_a, time_b;
    logic        wrong_a, wrong_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    binary_quiz_engine #(.WIDTH(WIDTH), .SCORE_W(8), .LIVES(LIVES), .TIME_LIMIT(TLIM), .SEED(1)) dut (
        .Clk(clk), .Reset_n(rst_n), .CEN(cen), .Select(Select), .Quit(Quit),
        .selectLeft(selectLeft), .selectRight(selectRight), .userNumber(userNumber),
        .outputNumber(num_a), .playerScore(score_a), .highScore(high_a), .livesLeft(lives_a),
        .timeLeft(time_a), .isWrong(wrong_a), .stateOut(state_a));

    binary_quiz_engine #(.WIDTH(WIDTH), .SCORE_W(2), .LIVES(LIVES), .TIME_LIMIT(TLIM), .SEED(1)) dut_sat (
        .Clk(clk), .Reset_n(rst_n), .CEN(cen), .Select(Select), .Quit(Quit),
        .selectLeft(selectLeft), .selectRight(selectRight), .userNumber(userNumber),
        .outputNumber(num_b), .playerScore(score_b), .highScore(high_b), .livesLeft(lives_b),
        .timeLeft(time_b), .isWrong(wrong_b), .stateOut(state_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Numbers come from the x^4+x^3+1 sequence starting at 1,
    // one step per clock edge since reset.
    int lfsr_seq [15] = '{1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2};
    state_t m_state = S_INIT;
    int m_cursor = 0, m_num = 0, m_score_a = 0, m_score_b = 0, m_high_a = 0, m_high_b = 0;
    int m_lives = 0, m_time = 0, m_wrong = 0, m_edges = 0, m_rnd, m_pressed;
    bit m_sel, m_quit, m_left, m_right, m_missed;

    task automatic enter_over();
        m_state = S_OVER;
        m_num   = 0;
        if (m_score_a > m_high_a) m_high_a = m_score_a;
        if (m_score_b > m_high_b) m_high_b = m_score_b;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = S_INIT; m_cursor = 0; m_num = 0; m_score_a = 0; m_score_b = 0;
            m_high_a = 0; m_high_b = 0; m_lives = 0; m_time = 0; m_wrong = 0; m_edges = 0;
        end else begin
            m_rnd = lfsr_seq[m_edges % 15];
            m_edges++;
            m_pressed = int'(Select) + int'(Quit) + int'(selectLeft) + int'(selectRight);
            m_sel   = cen && m_pressed == 1 && Select;
            m_quit  = cen && m_pressed == 1 && Quit;
            m_left  = cen && m_pressed == 1 && selectLeft;
            m_right = cen && m_pressed == 1 && selectRight;
            if (cen) begin
                case (m_state)
                    S_INIT: m_state = S_MENU;
                    S_MENU: begin
                        if (m_left) m_cursor = (m_cursor + 3) % 4;
                        else if (m_right) m_cursor = (m_cursor + 1) % 4;
                        else if (m_sel) begin
                            if (m_cursor == 0) begin
                                m_state = S_P_LOAD; m_score_a = 0; m_score_b = 0; m_lives = LIVES;
                            end else if (m_cursor == 1) m_state = S_R_LOAD;
                            else if (m_cursor == 2) m_state = S_SCORES;
                            else m_state = S_DONE;
                        end
                    end
                    S_P_LOAD: begin m_num = m_rnd; m_time = TLIM; m_state = S_P_WAIT; end
                    S_P_WAIT: begin
                        m_time--;
                        m_missed = 0;
                        if (m_quit) enter_over();
                        else if (m_sel) begin
                            if (int'(userNumber) == m_num) begin
                                if (m_score_a < 255) m_score_a++;
                                if (m_score_b < 3) m_score_b++;
                                m_wrong = 0;
                                m_state = S_P_LOAD;
                            end else m_missed = 1;
                        end else if (m_time == 0) m_missed = 1;
                        if (m_missed) begin
                            m_lives--;
                            m_wrong = 1;
                            if (m_lives == 0) enter_over();
                            else m_state = S_P_LOAD;
                        end
                    end
                    S_OVER: if (m_sel) m_state = S_SCORES;
                    S_R_LOAD: begin m_num = m_rnd; m_state = S_R_WAIT; end
                    S_R_WAIT: begin
                        if (m_sel) begin
                            m_wrong = (int'(userNumber) != m_num);
                            if (m_wrong == 0) m_state = S_R_LOAD;
                        end else if (m_quit) begin
                            m_state = S_MENU; m_num = 0;
                        end
                    end
                    S_SCORES: if (m_sel || m_quit) begin m_state = S_MENU; m_cursor = 2; end
                    S_DONE: if (m_sel) m_state = S_INIT;
                    default: m_state = S_INIT;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("state", state_a, m_state);
        check("state_sat", state_b, m_state);
        check("number", num_a, m_num);
        check("score", score_a, m_score_a);
        check("score_sat", score_b, m_score_b);
        check("high", high_a, m_high_a);
        check("high_sat", high_b, m_high_b);
        check("lives", lives_a, m_lives);
        check("time", time_a, m_time);
        check("wrong", wrong_a, m_wrong);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic s, input logic q, input logic l, input logic r);
        Select = s; Quit = q; selectLeft = l; selectRight = r;
        @(posedge clk); #1;
        {Select, Quit, selectLeft, selectRight} = 4'b0000;
    endtask

    task automatic answer(input bit correct);
        logic [3:0] n;
        n = 4'(m_num);
        userNumber = correct ? n : ~n;
        press(1, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        {Select, Quit, selectLeft, selectRight} = 4'b0000;
        cen = 1'b1;
        userNumber = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_state", state_a, 0);
        check("rst_number", num_a, 0);
        check("rst_lives", lives_a, 0);
        @(posedge clk); #1;
        check("init_to_menu", state_a, S_MENU);

        repeat (4) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        check("right4_is_play", state_a, S_P_LOAD);
        idle(1);
        check("first_number", num_a, 4'h5);
        check("first_time", time_a, 5);
        check("first_lives", lives_a, 2);

        repeat (3) begin answer(1); idle(1); end
        answer(0);
        check("wrong1_lives", lives_a, 1);
        check("wrong1_flag", wrong_a, 1);
        check("wrong1_state", state_a, S_P_LOAD);
        idle(1);
        answer(0);
        check("over_state", state_a, S_OVER);
        check("over_score", score_a, 3);
        check("over_lives", lives_a, 0);
        check("over_high", high_a, 3);
        check("over_number", num_a, 0);

        press(1, 0, 0, 0);
        check("over_to_scores", state_a, S_SCORES);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("left_from_play_quit", state_a, S_DONE);
        press(1, 0, 0, 0);
        check("done_to_init", state_a, S_INIT);
        check("done_keeps_high", high_a, 3);
        idle(1);
        press(0, 0, 0, 1);
        press(1, 0, 0, 1);
        check("multi_press_ignored", state_a, S_MENU);
        press(1, 0, 0, 0);
        check("cursor_kept_play", state_a, S_P_LOAD);

        for (int t = TLIM; t >= 1; t--) begin
            idle(1);
            check("timer_count", time_a, t);
            check("timer_state", state_a, S_P_WAIT);
        end
        idle(1);
        check("timeout_time", time_a, 0);
        check("timeout_state", state_a, S_P_LOAD);
        check("timeout_wrong", wrong_a, 1);
        check("timeout_lives", lives_a, 1);
        idle(5);
        check("pre_quit_time", time_a, 1);
        press(0, 1, 0, 0);
        check("quit_timeout_state", state_a, S_OVER);
        check("quit_timeout_lives", lives_a, 1);
        check("quit_timeout_high", high_a, 3);

        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("practice_load", state_a, S_R_LOAD);
        idle(1);
        answer(0);
        check("practice_wrong_state", state_a, S_R_WAIT);
        check("practice_wrong_flag", wrong_a, 1);
        answer(1);
        check("practice_right_state", state_a, S_R_LOAD);
        check("practice_right_flag", wrong_a, 0);
        idle(1);
        press(0, 1, 0, 0);
        check("practice_quit_state", state_a, S_MENU);
        check("practice_quit_number", num_a, 0);

        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        idle(1);
        repeat (5) begin answer(1); idle(1); end
        check("five_correct_score", score_a, 5);
        check("saturated_score", score_b, 3);

        rst_n = 1'b0;
        #2;
        check("midgame_rst_state", state_a, S_INIT);
        check("midgame_rst_score", score_a, 0);
        check("midgame_rst_high", high_a, 0);
        check("midgame_rst_time", time_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cen = 1'b0;
        idle(3);
        check("cen_low_holds_init", state_a, S_INIT);
        cen = 1'b1;
        idle(1);
        check("cen_high_to_menu", state_a, S_MENU);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
